// File: rtl/button_event_arbiter.sv
// button_event_arbiter
//   Debounces N_BTN raw push-buttons, turns each debounced press into a
//   one-shot event, and shares one valid/ready event port between all
//   channels with round-robin arbitration.
//   Optional feature macro: BTN_AUTOREPEAT_EN (per-channel auto-repeat events
//   while a button is held). Without it evt_repeat is tied low.
//
// Handshake: evt_valid/evt_id/evt_repeat are held stable while evt_ready is
//   low; one event transfers on every clock edge where evt_valid && evt_ready
//   are both high. evt_ready is ignored while evt_valid is low.
module button_event_arbiter #(
  parameter int N_BTN         = 4,
  parameter int DEB_CYCLES    = 20,
  parameter int REPEAT_CYCLES = 25_000_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_BTN-1:0]         btn_raw,
  output logic [N_BTN-1:0]         btn_level,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(N_BTN)-1:0] evt_id,
  output logic                     evt_repeat,
  output logic                     evt_drop
);

  localparam int IDW = $clog2(N_BTN);
  localparam int DCW = $clog2(DEB_CYCLES + 1);
  localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CYCLES - 1);

  // Elaboration-time guard on the configuration range.
  if (N_BTN < 2 || DEB_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("button_event_arbiter: illegal parameter values");
  end

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Input synchroniser and debounce state
  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [N_BTN-1:0] level_q, level_d;
  logic [DCW-1:0]   deb_cnt_q [N_BTN];
  logic [DCW-1:0]   deb_cnt_d [N_BTN];

  // Event sources
  logic [N_BTN-1:0] press_init;
  logic [N_BTN-1:0] press;

  // Arbitration and output state
  state_t           state_q, state_d;
  logic [N_BTN-1:0] pend_q, pend_d;
  logic             drop_q, drop_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             any_pend;
  logic             grant;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   win_hi, win_lo;
  logic             found_hi, found_lo;
  logic [N_BTN-1:0] grant_clr;

  // Two-flop synchroniser on every raw button input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive cycles the synced value differs from the
  // level; a cycle where it matches again clears the count. Since the input
  // is one bit, any change of a differing value makes it match, so this also
  // restarts the count on every bounce. The count stops at DEB_LAST because
  // reaching it commits the level and clears the counter.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < N_BTN; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          level_d[i]   = sync2_q[i];
          deb_cnt_d[i] = '0;
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounced level and per-channel stability counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      for (int i = 0; i < N_BTN; i++) deb_cnt_q[i] <= '0;
    end else begin
      level_q <= level_d;
      for (int i = 0; i < N_BTN; i++) deb_cnt_q[i] <= deb_cnt_d[i];
    end
  end

  // A press is the debounced level rising; it is flagged on the same edge
  // the level flips so the event can be granted on the following edge.
  assign press_init = level_d & ~level_q;

`ifdef BTN_AUTOREPEAT_EN
  localparam int RCW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RCW-1:0] REP_LAST = RCW'(REPEAT_CYCLES - 1);

  logic [RCW-1:0]   hold_cnt_q [N_BTN];
  logic [RCW-1:0]   hold_cnt_d [N_BTN];
  logic [N_BTN-1:0] press_rep;
  logic [N_BTN-1:0] tag_q, tag_d;
  logic             rep_q, rep_d;

  // Hold counters: fire a repeat press every REPEAT_CYCLES cycles the level
  // has been (and stays) high; releasing the button clears the counter.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      hold_cnt_d[i] = '0;
      press_rep[i]  = 1'b0;
      if (level_q[i] && level_d[i]) begin
        if (hold_cnt_q[i] == REP_LAST) begin
          press_rep[i]  = 1'b1;
          hold_cnt_d[i] = '0;
        end else begin
          hold_cnt_d[i] = hold_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Hold counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BTN; i++) hold_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) hold_cnt_q[i] <= hold_cnt_d[i];
    end
  end

  // Initial and repeat presses are mutually exclusive per channel (one
  // needs the old level low, the other high).
  assign press = press_init | press_rep;

  // Repeat tag follows the most recent press that set the pending bit.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      tag_d[i] = press[i] ? press_rep[i] : tag_q[i];
    end
    rep_d = grant ? tag_q[winner] : rep_q;
  end

  assign evt_repeat = rep_q;
`else
  assign press      = press_init;
  assign evt_repeat = 1'b0;
`endif

  // Round-robin pick: lowest pending index above the pointer, otherwise the
  // lowest pending index at or below it (wrap from N_BTN-1 to 0).
  always_comb begin
    win_hi   = '0;
    win_lo   = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int j = 0; j < N_BTN; j++) begin
      if (pend_q[j]) begin
        if (j > int'(rr_q)) begin
          if (!found_hi) begin
            found_hi = 1'b1;
            win_hi   = IDW'(j);
          end
        end else if (!found_lo) begin
          found_lo = 1'b1;
          win_lo   = IDW'(j);
        end
      end
    end
    winner   = found_hi ? win_hi : win_lo;
    any_pend = |pend_q;
  end

  // Output FSM next state: EMPTY loads the winner; FULL holds until the
  // handshake and then either reloads the next winner or drains to EMPTY.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    rr_d    = rr_q;
    grant   = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (any_pend) grant = 1'b1;
      end
      ST_FULL: begin
        if (evt_ready) begin
          if (any_pend) grant = 1'b1;
          else          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (grant) begin
      state_d = ST_FULL;
      id_d    = winner;
      rr_d    = winner;
    end
    for (int j = 0; j < N_BTN; j++) begin
      grant_clr[j] = grant && (winner == IDW'(j));
    end
    // A same-cycle press on the granted channel re-arms it and is not a drop.
    pend_d = (pend_q & ~grant_clr) | press;
    drop_d = drop_q | (|(press & pend_q & ~grant_clr));
  end

  // Output FSM, pending set, round-robin pointer and sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      id_q    <= '0;
      rr_q    <= IDW'(N_BTN - 1);
      pend_q  <= '0;
      drop_q  <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      tag_q   <= '0;
      rep_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
`ifdef BTN_AUTOREPEAT_EN
      tag_q   <= tag_d;
      rep_q   <= rep_d;
`endif
    end
  end

  assign btn_level = level_q;
  assign evt_valid = (state_q == ST_FULL);
  assign evt_id    = id_q;
  assign evt_drop  = drop_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Bench for button_event_arbiter with N_BTN=4, DEB_CYCLES=4, REPEAT_CYCLES=16.
// Expected events are queued as {repeat, id} when stimulus is issued; the
// monitor pops one entry per accepted handshake.
module tb_button_event_arbiter;

  localparam int N_BTN = 4;
  localparam int DEB   = 4;
  localparam int REP   = 16;
  localparam int IDW   = 2;
  localparam int EW    = IDW + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic             evt_valid;
  logic             evt_ready;
  logic [IDW-1:0]   evt_id;
  logic             evt_repeat;
  logic             evt_drop;

  int               checks = 0;
  int               errors = 0;
  logic [EW-1:0]    exp_q[$];
  logic [EW-1:0]    mon_exp;

  // Clock and reset
  always #5 clk = ~clk;

  button_event_arbiter #(
    .N_BTN        (N_BTN),
    .DEB_CYCLES   (DEB),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .evt_repeat(evt_repeat),
    .evt_drop  (evt_drop)
  );

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push_evt(input logic rep, input logic [IDW-1:0] id);
    exp_q.push_back({rep, id});
  endfunction

  task automatic do_reset();
    rst_n     = 1'b0;
    btn_raw   = '0;
    evt_ready = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    exp_q.delete();
  endtask

  task automatic wait_valid(input string name, input int max);
    int n;
    n = 0;
    while (!evt_valid && n < max) begin
      tick(1);
      n++;
    end
    check(name, 32'(evt_valid), 32'd1);
  endtask

  task automatic wait_drain(input string name, input int max);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max) begin
      tick(1);
      n++;
    end
    tick(4);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard monitor: one expected entry per accepted event.
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL evt_extra: got id=%0d rep=%0d expected no event", evt_id, evt_repeat);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({evt_repeat, evt_id} !== mon_exp) begin
          errors++;
          $display("FAIL evt_order: got rep=%0d id=%0d expected rep=%0d id=%0d",
                   evt_repeat, evt_id, mon_exp[IDW], mon_exp[IDW-1:0]);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    rst_n     = 1'b0;
    btn_raw   = '0;
    evt_ready = 1'b0;
    #12;
    check("rst_level",  32'(btn_level),  32'd0);
    check("rst_valid",  32'(evt_valid),  32'd0);
    check("rst_id",     32'(evt_id),     32'd0);
    check("rst_repeat", 32'(evt_repeat), 32'd0);
    check("rst_drop",   32'(evt_drop),   32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // 1: reset while FULL discards the held event; channel 0 wins afterwards
    btn_raw = 4'b1111;
    wait_valid("t1_valid", 20);
    check("t1_first_id", 32'(evt_id), 32'd0);
    tick(3);
    rst_n = 1'b0;
    #1;
    check("t1_rst_valid", 32'(evt_valid),  32'd0);
    check("t1_rst_id",    32'(evt_id),     32'd0);
    check("t1_rst_level", 32'(btn_level),  32'd0);
    check("t1_rst_rep",   32'(evt_repeat), 32'd0);
    check("t1_rst_drop",  32'(evt_drop),   32'd0);
    tick(2);
    rst_n = 1'b1;
    push_evt(1'b0, 2'd0);
    push_evt(1'b0, 2'd1);
    push_evt(1'b0, 2'd2);
    push_evt(1'b0, 2'd3);
    evt_ready = 1'b1;
    wait_drain("t1_drain", 40);
    check("t1_drop", 32'(evt_drop), 32'd0);
    btn_raw = '0;
    tick(10);

    // 2: bounce on button 1, then a stable high
    do_reset();
    evt_ready = 1'b1;
    push_evt(1'b0, 2'd1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick(2);
      btn_raw[1] = ~btn_raw[1];
    end
    tick(5);
    check("t2_level_early", 32'(btn_level[1]), 32'd0);
    tick(1);
    check("t2_level_rise",  32'(btn_level[1]), 32'd1);
    check("t2_valid_early", 32'(evt_valid),    32'd0);
    tick(1);
    check("t2_valid",       32'(evt_valid),    32'd1);
    check("t2_id",          32'(evt_id),       32'd1);
    wait_drain("t2_drain", 20);
    btn_raw = '0;
    tick(10);

    // 3: simultaneous presses on 0, 1, 3 drain back to back
    do_reset();
    evt_ready = 1'b1;
    push_evt(1'b0, 2'd0);
    push_evt(1'b0, 2'd1);
    push_evt(1'b0, 2'd3);
    btn_raw = 4'b1011;
    wait_valid("t3_valid", 20);
    check("t3_id0", 32'(evt_id), 32'd0);
    tick(1);
    check("t3_vid1", 32'({evt_valid, evt_id}), 32'b101);
    tick(1);
    check("t3_vid3", 32'({evt_valid, evt_id}), 32'b111);
    tick(1);
    check("t3_empty", 32'(evt_valid), 32'd0);
    wait_drain("t3_drain", 20);
    btn_raw = '0;
    tick(10);

    // 4: backpressure holds the event; a second re-press while pending drops
    do_reset();
    btn_raw = 4'b0100;
    wait_valid("t4_valid", 20);
    check("t4_id", 32'(evt_id), 32'd2);
    for (int k = 0; k < 10; k++) begin
      tick(1);
      check("t4_hold", 32'({evt_valid, evt_id}), 32'b110);
    end
    btn_raw = '0;
    tick(8);
    btn_raw = 4'b0100;
    tick(8);
    check("t4_no_drop", 32'(evt_drop), 32'd0);
    btn_raw = '0;
    tick(8);
    btn_raw = 4'b0100;
    tick(8);
    check("t4_drop",    32'(evt_drop), 32'd1);
    check("t4_hold_end", 32'({evt_valid, evt_id}), 32'b110);
    push_evt(1'b0, 2'd2);
    push_evt(1'b0, 2'd2);
    evt_ready = 1'b1;
    wait_drain("t4_drain", 20);
    check("t4_drop_sticky", 32'(evt_drop), 32'd1);
    btn_raw = '0;
    tick(10);

    // 5: fairness, button 3 is served before button 0's second event
    do_reset();
    btn_raw = 4'b1001;
    wait_valid("t5_valid", 20);
    check("t5_id0", 32'(evt_id), 32'd0);
    btn_raw = 4'b1000;
    tick(8);
    btn_raw = 4'b1001;
    tick(8);
    check("t5_no_drop", 32'(evt_drop), 32'd0);
    push_evt(1'b0, 2'd0);
    push_evt(1'b0, 2'd3);
    push_evt(1'b0, 2'd0);
    evt_ready = 1'b1;
    wait_drain("t5_drain", 20);
    btn_raw = '0;
    tick(10);

    // 6: long hold on button 2
    do_reset();
    evt_ready = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
    push_evt(1'b0, 2'd2);
    push_evt(1'b1, 2'd2);
    push_evt(1'b1, 2'd2);
    push_evt(1'b1, 2'd2);
`else
    push_evt(1'b0, 2'd2);
`endif
    btn_raw = 4'b0100;
    tick(50);
    btn_raw = '0;
    wait_drain("t6_drain", 40);
    tick(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
